debug_display_ctrl: RTL



---
 rtl/debug_display_pkg.sv | 27 ++
 rtl/debug_display_ctrl_hex_to_seg7.sv | 11 +
 rtl/debug_display_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/debug_display_pkg.sv
// rtl/debug_display_pkg.sv - register map, display modes and hex font for debug_display_ctrl
package debug_display_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_VALUE  = 4'd1;
    localparam logic [3:0] ADDR_BLINK  = 4'd2;
    localparam logic [3:0] ADDR_LEDS   = 4'd3;
    localparam logic [3:0] ADDR_PUSH   = 4'd4;
    localparam logic [3:0] ADDR_RATE   = 4'd5;
    localparam logic [3:0] ADDR_STATUS = 4'd6;

    typedef enum logic [1:0] {
        MODE_HEX    = 2'd0,
        MODE_RAW    = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low g..a patterns, entry 0 in the least-significant slot.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/debug_display_ctrl_hex_to_seg7.sv
// rtl/debug_display_ctrl_hex_to_seg7.sv - combinational nibble to active-low seven-segment decoder
module hex_to_seg7
    import debug_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_FONT[nibble];

endmodule

// File: rtl/debug_display_ctrl.sv
// rtl/debug_display_ctrl.sv - Avalon-MM debug display: hex/raw/scroll digits with blink, plus LEDs
module debug_display_ctrl
    import debug_display_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int NUM_LEDS      = 10,
    parameter int CLK_HZ        = 50_000_000,
    parameter int SCROLL_DEPTH  = 16,
    parameter int BLINK_HALF_MS = 250
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              avs_address,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [31:0]             avs_writedata,
    output logic [31:0]             avs_readdata,
    output logic [7*NUM_DIGITS-1:0] seg_conduit,
    output logic [NUM_LEDS-1:0]     light_conduit
);

    localparam int PRESC_DIV = CLK_HZ / 1000;
    localparam int PRE_W     = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam int BLK_W     = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
    localparam int PTR_W     = (SCROLL_DEPTH > 1) ? $clog2(SCROLL_DEPTH) : 1;
    localparam int CNT_W     = $clog2(SCROLL_DEPTH) + 1;
    localparam int SUM_W     = CNT_W + 1;

    logic                  enable, blank_lz, overflow, phase;
    mode_e                 mode;
    logic [31:0]           value_reg;
    logic [NUM_DIGITS-1:0] blink_reg;
    logic [NUM_LEDS-1:0]   leds_reg;
    logic [15:0]           rate_reg, rate_cnt;
    logic [6:0]            raw_reg [8];
    logic [6:0]            fifo_mem [SCROLL_DEPTH];
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      offset;
    logic [PRE_W-1:0]      presc_cnt;
    logic [BLK_W-1:0]      blink_cnt;

    logic tick, rate_wr, step, push, clear, raw_hit;

    assign tick    = (presc_cnt == PRE_W'(PRESC_DIV - 1));
    assign rate_wr = avs_write && (avs_address == ADDR_RATE);
    assign push    = avs_write && (avs_address == ADDR_PUSH);
    assign clear   = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[4];
    assign raw_hit = avs_address[3] && ({1'b0, avs_address[2:0]} < 4'(NUM_DIGITS));
    // A RATE write restarts the period, so it also suppresses a coincident step.
    assign step    = tick && !rate_wr && (rate_reg != 16'd0) && (rate_cnt == rate_reg - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            enable    <= 1'b0;
            mode      <= MODE_HEX;
            blank_lz  <= 1'b0;
            value_reg <= '0;
            blink_reg <= '0;
            leds_reg  <= '0;
            rate_reg  <= '0;
            for (int i = 0; i < 8; i++) raw_reg[i] <= '0;
        end else if (avs_write) begin
            case (avs_address)
                ADDR_CTRL: begin
                    enable   <= avs_writedata[0];
                    mode     <= mode_e'(avs_writedata[2:1]);
                    blank_lz <= avs_writedata[3];
                end
                ADDR_VALUE: value_reg <= avs_writedata;
                ADDR_BLINK: blink_reg <= avs_writedata[NUM_DIGITS-1:0];
                ADDR_LEDS:  leds_reg  <= avs_writedata[NUM_LEDS-1:0];
                ADDR_RATE:  rate_reg  <= avs_writedata[15:0];
                default: if (raw_hit) raw_reg[avs_address[2:0]] <= avs_writedata[6:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_cnt <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            rate_cnt  <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) begin
                if (blink_cnt == BLK_W'(BLINK_HALF_MS - 1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
            if (rate_wr)
                rate_cnt <= '0;
            else if (tick && rate_reg != 16'd0)
                rate_cnt <= step ? 16'd0 : rate_cnt + 16'd1;
        end
    end

    // Entries are never popped, so the oldest entry always sits at index 0.
    always_ff @(posedge clk) begin
        if (!reset && push && count != CNT_W'(SCROLL_DEPTH))
            fifo_mem[count[PTR_W-1:0]] <= avs_writedata[6:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            offset   <= '0;
            overflow <= 1'b0;
        end else begin
            if (avs_write && avs_address == ADDR_STATUS && avs_writedata[0])
                overflow <= 1'b0;
            if (clear) begin
                count  <= '0;
                offset <= '0;
            end else begin
                if (push) begin
                    if (count == CNT_W'(SCROLL_DEPTH)) overflow <= 1'b1;
                    else                               count    <= count + 1'b1;
                end
                if (step) begin
                    if (count <= CNT_W'(1) || CNT_W'(offset) == count - CNT_W'(1))
                        offset <= '0;
                    else
                        offset <= offset + 1'b1;
                end
            end
        end
    end

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL:   rd_mux = {28'd0, blank_lz, mode, enable};
            ADDR_VALUE:  rd_mux = value_reg;
            ADDR_BLINK:  rd_mux = 32'(blink_reg);
            ADDR_LEDS:   rd_mux = 32'(leds_reg);
            ADDR_PUSH:   rd_mux = 32'({count, count == CNT_W'(SCROLL_DEPTH), count == '0});
            ADDR_RATE:   rd_mux = {16'd0, rate_reg};
            ADDR_STATUS: rd_mux = {30'd0, phase, overflow};
            default:     if (raw_hit) rd_mux = {25'd0, raw_reg[avs_address[2:0]]};
        endcase
    end

    logic [6:0] hex_seg [NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_font
        hex_to_seg7 u_hex (
            .nibble (value_reg[4*g +: 4]),
            .seg    (hex_seg[g])
        );
    end

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_above;
    logic [7*NUM_DIGITS-1:0] next_seg;
    logic [6:0]              digit;
    logic [SUM_W-1:0]        pos, idx;

    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (value_reg[4*k +: 4] == 4'd0);
            lz_mask[k] = zero_above;
        end
    end

    always_comb begin
        next_seg = '1;
        digit    = SEG_BLANK;
        pos      = '0;
        idx      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit = SEG_BLANK;
            pos   = SUM_W'(NUM_DIGITS - 1 - k);
            idx   = '0;
            if (enable) begin
                case (mode)
                    MODE_HEX:    if (!(blank_lz && lz_mask[k])) digit = hex_seg[k];
                    MODE_RAW:    digit = raw_reg[k];
                    MODE_SCROLL: if (pos < SUM_W'(count)) begin
                        // offset and pos are both below count, so one subtract is the modulo.
                        idx = SUM_W'(offset) + pos;
                        if (idx >= SUM_W'(count)) idx = idx - SUM_W'(count);
                        digit = fifo_mem[idx[PTR_W-1:0]];
                    end
                    default:     digit = SEG_BLANK;
                endcase
            end
            if (phase && blink_reg[k]) digit = SEG_BLANK;
            next_seg[7*(NUM_DIGITS-k)-1 -: 7] = digit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_conduit   <= '1;
            light_conduit <= '0;
            avs_readdata  <= '0;
        end else begin
            seg_conduit   <= next_seg;
            light_conduit <= leds_reg;
            if (avs_read) avs_readdata <= rd_mux;
        end
    end

endmodule
